// File: rtl/sprite_line_sequencer_if.sv
// Control/status bundle between the sprite-hit detector, the line sequencer
// and the sprite memory address generator.
interface sprite_line_sequencer_if #(
  parameter int unsigned CNT_W  = 5,
  parameter int unsigned PASS_W = 8
);
  logic              sprite_on;
  logic              clear;
  logic [1:0]        mode;
  logic [CNT_W-1:0]  line_limit;
  logic [CNT_W-1:0]  current_line;
  logic              count_finished;
  logic              line_done;
  logic              busy;
  logic [PASS_W-1:0] pass_count;

  modport master (
    output sprite_on, clear, mode, line_limit,
    input  current_line, count_finished, line_done, busy, pass_count
  );

  modport slave (
    input  sprite_on, clear, mode, line_limit,
    output current_line, count_finished, line_done, busy, pass_count
  );
endinterface

// File: rtl/sprite_line_sequencer.sv
// Steps the sprite row index through 0..L while sprite_on is high, with
// wrap / one-shot / hold behaviour, a terminal pulse and a saturating pass count.
module sprite_line_sequencer #(
  parameter int unsigned MAX_LINES = 20,
  parameter int unsigned CNT_W     = 5,
  parameter int unsigned PASS_W    = 8
) (
  input  logic                    clk_pixel,
  input  logic                    reset,
  sprite_line_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] LAST_LINE     = CNT_W'(MAX_LINES - 1);
  localparam logic [1:0]       MODE_ONE_SHOT = 2'b01;
  localparam logic [1:0]       MODE_HOLD     = 2'b10;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   lim_q, lim_d;
  logic [PASS_W-1:0]  pass_q, pass_d;
  logic               line_done_q, line_done_d;
  logic               fin_q, fin_d;
  logic               busy_q, busy_d;

  logic [CNT_W-1:0]   eff_lim;
  logic               mode_hold;
  logic               mode_one_shot;
  logic               do_step;

  // A zero or out-of-range request falls back to the full sprite height.
  always_comb begin
    eff_lim = bus.line_limit;
    if ((bus.line_limit == '0) || (bus.line_limit > LAST_LINE)) begin
      eff_lim = LAST_LINE;
    end
  end

  assign mode_hold     = (bus.mode == MODE_HOLD);
  assign mode_one_shot = (bus.mode == MODE_ONE_SHOT);

  // State and datapath registers.
  always_ff @(posedge clk_pixel or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      lim_q       <= LAST_LINE;
      pass_q      <= '0;
      line_done_q <= 1'b0;
      fin_q       <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      lim_q       <= lim_d;
      pass_q      <= pass_d;
      line_done_q <= line_done_d;
      fin_q       <= fin_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    lim_d       = lim_q;
    pass_d      = pass_q;
    line_done_d = 1'b0;
    do_step     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.sprite_on) begin
          state_d = S_COUNT;
          count_d = CNT_W'(1);
          lim_d   = eff_lim;
        end
      end
      S_COUNT: begin
        if (bus.sprite_on) begin
          do_step = 1'b1;
        end else if (mode_hold) begin
          state_d = S_PAUSE;
        end else begin
          state_d = S_IDLE;
          count_d = '0;
        end
      end
      S_PAUSE: begin
        if (bus.sprite_on) begin
          state_d = S_COUNT;
          do_step = 1'b1;
        end else if (!mode_hold) begin
          state_d = S_IDLE;
          count_d = '0;
        end
      end
      S_DONE: begin
        if (!bus.sprite_on) begin
          state_d = S_IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase

    // One counting step, shared by COUNT and the PAUSE resume edge.
    if (do_step) begin
      if (count_q == lim_q) begin
        line_done_d = 1'b1;
        if (pass_q != '1) begin
          pass_d = pass_q + PASS_W'(1);
        end
        if (mode_one_shot) begin
          state_d = S_DONE;
        end else begin
          count_d = '0;
          lim_d   = eff_lim;
        end
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end

    if (bus.clear) begin
      state_d     = S_IDLE;
      count_d     = '0;
      pass_d      = '0;
      line_done_d = 1'b0;
    end
  end

  // Status flags are precomputed from next-state values so they leave a flop.
  always_comb begin
    fin_d  = (state_d != S_COUNT) || (count_d == lim_d);
    busy_d = (state_d != S_IDLE);
  end

  assign bus.current_line   = count_q;
  assign bus.count_finished = fin_q;
  assign bus.line_done      = line_done_q;
  assign bus.busy           = busy_q;
  assign bus.pass_count     = pass_q;

endmodule

// File: doc/sprite_line_sequencer.md
# sprite_line_sequencer

Parametrised line sequencer for the sprite pipeline, generalising the fixed 20-state sprite line counter. While `sprite_on` is high it steps `current_line` through 0..L, where L is selectable at run time and capped by `MAX_LINES`. It adds wrap, one-shot and hold modes, a synchronous clear, a terminal pulse and a saturating pass counter. It sits between the sprite-hit detector and the sprite memory address generator; `current_line` selects the sprite row.

## Interface
- `MAX_LINES`, 20: number of lines per sprite. Must be ≥ 2.
- `CNT_W`, 5: width of the line counter. Requires 2^CNT_W ≥ MAX_LINES.
- `PASS_W`, 8: width of `pass_count`.
- `clk_pixel`  in  1  pixel clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low.
- `sprite_on`  in  1  count enable (level).
- `clear`  in  1  synchronous clear; highest priority after `reset`.
- `mode`  in  2  00 WRAP, 01 ONE_SHOT, 10 HOLD, 11 treated as WRAP.
- `line_limit`  in  CNT_W  requested terminal line.
- `current_line`  out  CNT_W  current line index.
- `count_finished`  out  1  high when not counting or at the terminal line.
- `line_done`  out  1  one-cycle pulse on reaching the terminal line.
- `busy`  out  1  high while a pass is in progress, paused or held.
- `pass_count`  out  PASS_W  number of completed passes, saturating.

## Operation
- **Effective limit** L = MAX_LINES-1 if `line_limit` is 0 or greater than MAX_LINES-1; otherwise L = `line_limit`.
  - L is latched into `lim_q` on exit from IDLE and on every wrap.
  - Changes to `line_limit` at any other time are ignored.
- **IDLE**: count = 0.
  - `sprite_on`=1 → COUNT with count = 1, `lim_q` latched.
- **COUNT**, `sprite_on`=1:
  - count < `lim_q`: count+1.
  - count == `lim_q`, WRAP or HOLD mode: count ← 0, `line_done` pulse, `pass_count`+1, `lim_q` relatched, stay in COUNT.
  - count == `lim_q`, ONE_SHOT mode: → DONE, count holds at `lim_q`, `line_done` pulse, `pass_count`+1.
- **COUNT**, `sprite_on`=0:
  - HOLD mode → PAUSE, count held.
  - Any other mode → IDLE, count ← 0.
- **PAUSE**:
  - `sprite_on`=1 → COUNT and performs the COUNT step on the same edge.
  - `sprite_on`=0 and `mode` not HOLD → IDLE, count ← 0.
  - Otherwise hold.
- **DONE**:
  - `sprite_on`=0 → IDLE, count ← 0.
  - Otherwise hold.
- **`clear`**=1: → IDLE, count ← 0, `pass_count` ← 0. Overrides `sprite_on` on the same edge.
- **`pass_count`** saturates at all-ones. It is cleared only by `reset` or `clear`.
- **Outputs**:
  - `count_finished` = (state ≠ COUNT) OR (count == `lim_q`). Decoded from registers only, with no combinational path from inputs.
  - `busy` = state ∈ {COUNT, PAUSE, DONE}.
  - A `mode` change mid-pass takes effect at the next decision point.

## Timing
- **Reset values**: `current_line` 0, `count_finished` 1, `line_done` 0, `busy` 0, `pass_count` 0, state IDLE, `lim_q` = MAX_LINES-1.
- **Async reset**: assertion forces reset values immediately, independent of `clk_pixel`. Deassertion is synchronised externally.
- **Latency**: `current_line`, `line_done` and `pass_count` are registered, so a change appears one edge after the sampled `sprite_on` or `clear`.
- **Pass length**: with `sprite_on` held, a WRAP pass is L+1 cycles. `line_done` is high during the cycle in which `current_line` is 0 after a wrap, or `lim_q` after entering DONE.
- **Single-edge deassert**: `sprite_on` low for a single edge in WRAP mode returns to 0. Re-assertion restarts at 1.

## Test plan
- **Reset**: reset low mid-pass at line 9 → all outputs immediately 0, except `count_finished` 1.
- **WRAP, default limit**: `mode`=00, `line_limit`=0, `sprite_on` high for 45 edges → `current_line` 1..19, 0, 1..19, 0, 1..5. `line_done` high after edges 20 and 40. `pass_count` = 2.
- **ONE_SHOT**: `mode`=01, `line_limit`=4 → lines 1, 2, 3, 4, then holds at 4. Single `line_done`. `count_finished` 1 from edge 4 and `busy` 1. After `sprite_on` drops, the next edge gives line 0 and `busy` 0.
- **HOLD**: `mode`=10, `line_limit`=7, on for 3 edges, then off for 5 edges → line stays 3, `busy` 1, `count_finished` 1. Re-assert → line 4 on the next edge.
- **Clamp and relatch**: `line_limit`=25 → wraps after 19. Change `line_limit` to 3 at line 10 → pass continues to 19, then wraps, then 1, 2, 3, 0.
- **Clear priority**: `clear`=1 with `sprite_on`=1 at line 12 and `pass_count`=5 → next edge gives line 0, `pass_count` 0, IDLE. Separately, `pass_count` with `PASS_W`=2 saturates at 3 after 5 passes.
